// File: rtl/bubble_pkg.sv
// Shared sizing and the bubble bit-pair type for the bubble page buffer.
package bubble_pkg;

  localparam int PAGE_DEPTH = 584;
  localparam int ADDR_W     = 11;

  // Bit 0 is the odd bubble, bit 1 the even bubble.
  typedef struct packed {
    logic even;
    logic odd;
  } bubble_pair_t;

endpackage

// File: rtl/bubble_page_dpram.sv
// Two-bank simple dual-port page RAM: one write port, one synchronous read port.
// The address MSB selects the bank; only the first PAGE_DEPTH entries of a bank are used.
module bubble_page_dpram
  import bubble_pkg::bubble_pair_t;
#(
  parameter int ADDR_W = bubble_pkg::ADDR_W
) (
  input  logic         master_clock,
  input  logic         wr_en,
  input  logic [ADDR_W:0] wr_addr,
  input  bubble_pair_t wr_data,
  input  logic         rd_en,
  input  logic [ADDR_W:0] rd_addr,
  output bubble_pair_t rd_data
);

  bubble_pair_t mem [0:(2**(ADDR_W+1))-1];

  // NOTE: the array has no reset so it maps onto block RAM; page contents survive reset.
  always_ff @(posedge master_clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bubble_page_buffer.sv
// Ping-pong page store between the SPI page loader and the bubble output path.
// Optional sticky underrun detection is built when BUBBLE_PAGE_BUFFER_UNDERRUN_EN is defined.
module bubble_page_buffer
  import bubble_pkg::bubble_pair_t;
#(
  parameter int PAGE_DEPTH = bubble_pkg::PAGE_DEPTH,
  parameter int ADDR_W     = bubble_pkg::ADDR_W
) (
  input  logic              master_clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] bubble_buffer_write_address,
  input  logic [1:0]        bubble_buffer_write_data_input,
  input  logic              bubble_buffer_write_enable,
  input  logic              load_done,
  input  logic              page_swap,
  input  logic              data_out_notice,
  input  logic              data_out_strobe,
  output logic              bubble_out_odd,
  output logic              bubble_out_even,
  output logic              fill_bank_free,
  output logic              page_valid,
  output logic              underrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAGE_DEPTH - 1);

  logic              fill_bank, fill_full, page_valid_q;
  logic [ADDR_W-1:0] read_ptr;

  logic              eff_full, swap_ok, wr_ok, rd_fire;
  logic              fill_bank_nxt, fill_full_nxt, page_valid_nxt;
  logic [ADDR_W-1:0] ptr_base, read_ptr_nxt;

  logic              strobe_d, fire_d;
  bubble_pair_t      rd_data, out_pair;

  // NOTE: combinational next-state uses blocking assignments with a default for
  // every output first, so no path can leave a value unassigned and infer a latch.
  always_comb begin
    eff_full       = fill_full | load_done;
    swap_ok        = page_swap & eff_full;
    wr_ok          = bubble_buffer_write_enable & ~fill_full &
                     (bubble_buffer_write_address <= LAST_ADDR);
    fill_bank_nxt  = fill_bank ^ swap_ok;
    page_valid_nxt = page_swap ? eff_full : page_valid_q;
    fill_full_nxt  = swap_ok ? 1'b0 : (fill_full | load_done);
    // A swap or notice rewinds before any strobe in the same cycle is served.
    ptr_base       = (page_swap | data_out_notice) ? '0 : read_ptr;
    rd_fire        = data_out_strobe & page_valid_nxt;
    read_ptr_nxt   = ptr_base;
    if (rd_fire) read_ptr_nxt = (ptr_base == LAST_ADDR) ? '0 : ptr_base + 1'b1;
  end

  bubble_page_dpram #(.ADDR_W(ADDR_W)) u_ram (
    .master_clock (master_clock),
    .wr_en        (wr_ok),
    .wr_addr      ({fill_bank, bubble_buffer_write_address}),
    .wr_data      (bubble_pair_t'(bubble_buffer_write_data_input)),
    .rd_en        (rd_fire),
    .rd_addr      ({~fill_bank_nxt, ptr_base}),
    .rd_data      (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge master_clock) begin
    if (reset) begin
      fill_bank    <= 1'b0;
      fill_full    <= 1'b0;
      page_valid_q <= 1'b0;
      read_ptr     <= '0;
      strobe_d     <= 1'b0;
      fire_d       <= 1'b0;
      out_pair     <= '0;
    end else begin
      fill_bank    <= fill_bank_nxt;
      fill_full    <= fill_full_nxt;
      page_valid_q <= page_valid_nxt;
      read_ptr     <= read_ptr_nxt;
      strobe_d     <= data_out_strobe;
      fire_d       <= rd_fire;
      // Outputs change one edge after the RAM read; a strobe with no page emits 00.
      if (strobe_d) out_pair <= fire_d ? rd_data : '0;
    end
  end

  assign bubble_out_odd  = out_pair.odd;
  assign bubble_out_even = out_pair.even;
  assign fill_bank_free  = ~fill_full;
  assign page_valid      = page_valid_q;

`ifdef BUBBLE_PAGE_BUFFER_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge master_clock) begin
    if (reset) underrun_q <= 1'b0;
    else if ((data_out_strobe & ~page_valid_nxt) | (page_swap & ~eff_full))
      underrun_q <= 1'b1;
  end

  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: doc/bubble_page_buffer.md
# bubble_page_buffer

Ping-pong page store between the SPI page loader and the bubble output path. The loader writes one page of 2-bit odd/even bubble pairs into the fill bank. On each page latch the filled bank becomes the read bank. The timing strobes then shift it out on `bubble_out_odd` and `bubble_out_even`.

## Interface
- `PAGE_DEPTH`, 584: bit-pair positions per page.
- `ADDR_W`, 11: address width; must satisfy 2^ADDR_W ≥ PAGE_DEPTH.
- `master_clock` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `bubble_buffer_write_address` in ADDR_W: loader write position.
- `bubble_buffer_write_data_input` in 2: bit 0 is odd, bit 1 is even.
- `bubble_buffer_write_enable` in 1: write qualifier, one pair per cycle.
- `load_done` in 1: one-cycle pulse; the loader has finished the fill bank.
- `page_swap` in 1: one-cycle pulse from `position_latch`; requests a bank swap.
- `data_out_notice` in 1: one-cycle pulse; rewinds the read pointer to 0.
- `data_out_strobe` in 1: one-cycle pulse; emits the next pair.
- `bubble_out_odd` out 1: registered odd bubble bit.
- `bubble_out_even` out 1: registered even bubble bit.
- `fill_bank_free` out 1: the fill bank accepts writes.
- `page_valid` out 1: the read bank holds a loaded page.
- `underrun` out 1: sticky flag (see Configuration).

## Operation
- State: `fill_bank`, `read_bank` = ~`fill_bank`, `fill_full`, `page_valid`, `read_ptr[ADDR_W-1:0]`.
- Reset values: `fill_bank` 0, `fill_full` 0, `page_valid` 0, `read_ptr` 0, both outputs 0, `underrun` 0. `fill_bank_free` is 1 after reset.
- `fill_bank_free` = ~`fill_full`.
- Write accept rule:
  - A write is accepted only when the enable is high, `fill_full` = 0 and the address < PAGE_DEPTH.
  - Any other write is silently dropped.
  - RAM contents are not cleared by reset.
- `load_done` sets `fill_full`. It has no effect if `fill_full` is already 1.
- `page_swap` uses `eff_full` = `fill_full` | `load_done` (same cycle).
  - If `eff_full` = 1:
    - `fill_bank` toggles;
    - `page_valid` goes to 1;
    - `fill_full` goes to 0;
    - `read_ptr` goes to 0.
  - If `eff_full` = 0:
    - `page_valid` goes to 0;
    - `read_ptr` goes to 0;
    - the banks are unchanged.
- `data_out_strobe`, evaluated after swap and notice in the same cycle:
  - If `page_valid` (post-swap) = 1: read `read_ptr` of the read bank, then `read_ptr` increments. At PAGE_DEPTH-1 it wraps to 0.
  - If `page_valid` = 0: the outputs are driven 0 and `read_ptr` is unchanged.
- `data_out_notice` sets `read_ptr` to 0. If a strobe occurs in the same cycle, it reads address 0 and `read_ptr` ends at 1.
- Outputs hold their value between strobes.

## Timing
- Write to RAM: the pair is stored at the clock edge on which it is accepted.
- Read latency: a strobe at edge N gives valid outputs after edge N+1 (synchronous RAM read, registered output).
- Swap effect: `fill_bank_free` and `page_valid` update after the swap edge. A strobe in the same cycle as the swap already reads the new bank, address 0.
- Read-during-write to the same physical entry cannot occur, because the banks are disjoint.
- Back-to-back strobes on every cycle are supported. The throughput is one pair per cycle.

## Configuration
- `BUBBLE_PAGE_BUFFER_UNDERRUN_EN` defined:
  - `underrun` is set on a strobe with `page_valid` = 0;
  - it is also set on a `page_swap` with `eff_full` = 0;
  - it stays set until `reset`.
- Not defined: `underrun` is tied to 0 and the detection logic is absent. All other behaviour is identical.

## Structure
- Package `bubble_pkg`: the `PAGE_DEPTH` and `ADDR_W` defaults, and the typedef for a bit pair (odd, even).
- Sub-module `bubble_page_dpram`:
  - 2×PAGE_DEPTH × 2-bit simple dual-port RAM;
  - one write port and one synchronous read port on `master_clock`;
  - the bank select is the address MSB.
- The top level holds the bank control, the read pointer and the output registers.

## Test plan
- Reset, then a strobe: outputs stay 0 and `page_valid` = 0. With the macro, `underrun` = 1; without it, `underrun` = 0.
- Fill page A with (addr mod 4), then `load_done`, then `page_swap`, then 584 strobes. Outputs after each strobe follow the sequence 00,01,10,11…. The 585th strobe returns pair 0 (wrap).
- Write while `fill_full` = 1, and write to address 600: the data is dropped. Bank contents read back unchanged after the next swap.
- `load_done` and `page_swap` in the same cycle, with a strobe also in that cycle: the swap succeeds, `page_valid` = 1, and the outputs show address 0 of the new bank on the next cycle.
- Strobe 10 pairs, then `data_out_notice` coincident with a strobe: that strobe outputs pair 0, and the next strobe outputs pair 1.
- `page_swap` with no completed fill: `page_valid` drops to 0 and the outputs go to 0 on the next strobe. Assert `reset` mid-page: all state returns to its reset values after one edge.
